// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit bridging a CPU request port to big-endian data memory and UART MMIO.
module mem_access_unit #(
  parameter int ADDR_W = 12,
  parameter int MEM_LAT = 1,
  parameter logic [3:0] MMIO_TAG = 4'h8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              stall,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_valid,
  output logic              uart_rx_ready
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, TXHOLD, RESP} state_t;
  state_t state, state_n;
  logic we_q, sgn_q, err_q;
  logic [1:0] size_q;
  logic [2:0] cnt;
  logic [31:0] addr_q, wdata_q, rdata_q, mmio_rd, ld_data, shb;
  logic [15:0] ld_h;
  logic [3:0] lanes;
  logic mis, mmio, tx_wr, rx_rd;
  assign mis = size_q == 2'b11 || (size_q == 2'b01 && addr_q[0]) || (size_q == 2'b10 && addr_q[1:0] != 2'b00);
  assign mmio = addr_q[31:28] == MMIO_TAG;
  assign tx_wr = mmio && we_q && addr_q[3:0] == 4'h8;
  assign rx_rd = mmio && !we_q && addr_q[3:0] == 4'hC;
  assign mmio_rd = we_q ? 32'd0 :
                   addr_q[3:0] == 4'h0 ? {31'd0, uart_tx_ready} :
                   addr_q[3:0] == 4'h4 ? {31'd0, uart_rx_valid} :
                   addr_q[3:0] == 4'hC ? {24'd0, uart_rx_data} : 32'd0;
  // big-endian: byte offset 0 sits in the top lane, so shift right by (3 - offset) bytes
  assign shb = mem_rdata >> {~addr_q[1:0], 3'b000};
  assign ld_h = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
  assign ld_data = size_q == 2'b00 ? {{24{sgn_q & shb[7]}}, shb[7:0]} :
                   size_q == 2'b01 ? {{16{sgn_q & ld_h[15]}}, ld_h} : mem_rdata;
  assign lanes = size_q == 2'b00 ? 4'b1000 >> addr_q[1:0] :
                 size_q == 2'b01 ? (addr_q[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign mem_addr = addr_q[ADDR_W+1:2];
  assign mem_wdata = size_q == 2'b00 ? {4{wdata_q[7:0]}} :
                     size_q == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
  assign uart_tx_data = wdata_q[7:0];
  assign req_ready = state == IDLE;
  assign stall = !req_ready;
  assign resp_valid = state == RESP;
  assign resp_rdata = resp_valid ? rdata_q : 32'd0;
  assign resp_err = resp_valid && err_q;
  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge CLK) begin
    if (state == IDLE && req_valid) begin
      we_q <= req_we;
      size_q <= req_size;
      sgn_q <= req_signed;
      addr_q <= req_addr;
      wdata_q <= req_wdata;
    end
    cnt <= state == WAIT ? cnt + 3'd1 : 3'd0;
    if (state == ISSUE) begin
      rdata_q <= (mis || !mmio) ? 32'd0 : mmio_rd;
      err_q <= mis;
    end
    if (state == WAIT) rdata_q <= ld_data;
  end
  always_comb begin
    state_n = state;
    mem_en = 1'b0;
    mem_we = 4'b0000;
    uart_tx_valid = 1'b0;
    uart_rx_ready = 1'b0;
    case (state)
      IDLE: state_n = req_valid ? ISSUE : IDLE;
      ISSUE:
        if (mis) state_n = RESP;
        else if (mmio) begin
          uart_tx_valid = tx_wr;
          uart_rx_ready = rx_rd;
          state_n = (tx_wr && !uart_tx_ready) ? TXHOLD : RESP;
        end else begin
          mem_en = 1'b1;
          mem_we = we_q ? lanes : 4'b0000;
          state_n = we_q ? RESP : WAIT;
        end
      WAIT: state_n = cnt == 3'(MEM_LAT - 1) ? RESP : WAIT;
      TXHOLD: begin
        uart_tx_valid = 1'b1;
        state_n = uart_tx_ready ? RESP : TXHOLD;
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of memory, MMIO, error and reset behaviour with MEM_LAT=2.
module tb_mem_access_unit;
  localparam int ADDR_W = 12;
  logic CLK = 0, reset = 1;
  logic req_valid = 0, req_ready, req_we = 0, req_signed = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic resp_valid, resp_err, stall, mem_en;
  logic [31:0] resp_rdata, mem_wdata;
  logic [31:0] mem_rdata = 32'h1122F344;
  logic [3:0] mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] uart_tx_data, uart_rx_data = 8'h5A;
  logic uart_tx_valid, uart_tx_ready = 1, uart_rx_valid = 0, uart_rx_ready;
  int n_chk = 0, n_fail = 0, rx_pulses = 0, lat, seen;

  mem_access_unit #(.ADDR_W(ADDR_W), .MEM_LAT(2), .MMIO_TAG(4'h8)) dut (
    .CLK(CLK), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall(stall), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) if (uart_rx_ready) rx_pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // leaves the bench at the negedge of cycle T+1 (ISSUE)
  task automatic send(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] wd);
    @(negedge CLK);
    req_valid = 1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge CLK);
    #1 req_valid = 0;
    @(negedge CLK);
  endtask

  task automatic wait_resp(output int l);
    l = 1;
    while (!resp_valid && l < 20) begin
      @(negedge CLK);
      l++;
    end
  endtask

  task automatic xact(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd, input logic e_en, input logic [3:0] e_we,
                      input logic [31:0] e_wd, input int e_lat, input logic [31:0] e_rd, input logic e_err);
    int l;
    send(we, sz, sg, a, wd);
    chk({tag, ".en"}, 32'(mem_en), 32'(e_en));
    chk({tag, ".we"}, 32'(mem_we), 32'(e_we));
    if (e_en) chk({tag, ".addr"}, 32'(mem_addr), 32'(a[ADDR_W+1:2]));
    chk({tag, ".wd"}, mem_wdata, e_wd);
    wait_resp(l);
    chk({tag, ".lat"}, 32'(l), 32'(e_lat));
    chk({tag, ".rd"}, resp_rdata, e_rd);
    chk({tag, ".err"}, 32'(resp_err), 32'(e_err));
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst.ready", 32'(req_ready), 1);
    chk("rst.stall", 32'(stall), 0);
    chk("rst.resp", {29'd0, resp_valid, resp_err, mem_en}, 0);
    chk("rst.rdata", resp_rdata, 0);
    chk("rst.mem_we", 32'(mem_we), 0);
    chk("rst.uart", {30'd0, uart_tx_valid, uart_rx_ready}, 0);
    @(posedge CLK);
    #1 reset = 0;
    // loads: rdata 0x1122F344
    xact("lb_s13", 0, 2'b00, 1, 32'h13, 0, 1, 4'b0000, 0, 4, 32'h00000044, 0);
    xact("lb_s12", 0, 2'b00, 1, 32'h12, 0, 1, 4'b0000, 0, 4, 32'hFFFFFFF3, 0);
    xact("lbu_12", 0, 2'b00, 0, 32'h12, 0, 1, 4'b0000, 0, 4, 32'h000000F3, 0);
    xact("lh_s0",  0, 2'b01, 1, 32'h00, 0, 1, 4'b0000, 0, 4, 32'h00001122, 0);
    xact("lh_s2",  0, 2'b01, 1, 32'h22, 0, 1, 4'b0000, 0, 4, 32'hFFFFF344, 0);
    xact("lhu_2",  0, 2'b01, 0, 32'h02, 0, 1, 4'b0000, 0, 4, 32'h0000F344, 0);
    xact("lw_4",   0, 2'b10, 1, 32'h104, 0, 1, 4'b0000, 0, 4, 32'h1122F344, 0);
    // stores
    xact("sh_6", 1, 2'b01, 0, 32'h06, 32'h0000BEEF, 1, 4'b0011, 32'hBEEFBEEF, 2, 0, 0);
    xact("sh_4", 1, 2'b01, 0, 32'h04, 32'h0000CAFE, 1, 4'b1100, 32'hCAFECAFE, 2, 0, 0);
    xact("sb_1", 1, 2'b00, 0, 32'h01, 32'h123456AB, 1, 4'b0100, 32'hABABABAB, 2, 0, 0);
    xact("sb_3", 1, 2'b00, 0, 32'h03, 32'h00000077, 1, 4'b0001, 32'h77777777, 2, 0, 0);
    xact("sw_8", 1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 1, 4'b1111, 32'hDEADBEEF, 2, 0, 0);
    // errors
    xact("lw_mis", 0, 2'b10, 0, 32'h02, 0, 0, 4'b0000, 0, 2, 0, 1);
    xact("sh_mis", 1, 2'b01, 0, 32'h01, 32'h1234, 0, 4'b0000, 32'h12341234, 2, 0, 1);
    xact("rsv",    0, 2'b11, 0, 32'h00, 0, 0, 4'b0000, 0, 2, 0, 1);
    // MMIO status and rx
    uart_tx_ready = 1; uart_rx_valid = 1;
    xact("mm_txst", 0, 2'b10, 0, 32'h80000000, 0, 0, 4'b0000, 0, 2, 1, 0);
    xact("mm_rxst", 0, 2'b10, 0, 32'h80000004, 0, 0, 4'b0000, 0, 2, 1, 0);
    xact("mm_other", 0, 2'b00, 0, 32'h80000002, 0, 0, 4'b0000, 0, 2, 0, 0);
    uart_rx_valid = 0;
    seen = rx_pulses;
    xact("mm_rx", 0, 2'b10, 0, 32'h8000000C, 0, 0, 4'b0000, 0, 2, 32'h5A, 0);
    chk("mm_rx.pulses", 32'(rx_pulses - seen), 1);
    seen = rx_pulses;
    xact("mm_wrC", 1, 2'b10, 0, 32'h8000000C, 32'h99, 0, 4'b0000, 32'h99, 2, 0, 0);
    chk("mm_wrC.pulses", 32'(rx_pulses - seen), 0);
    // stalled tx
    uart_tx_ready = 0;
    send(1, 2'b00, 0, 32'h80000008, 32'h41);
    for (int i = 0; i < 5; i++) begin
      chk("tx.valid", {31'd0, uart_tx_valid}, 1);
      chk("tx.data", 32'(uart_tx_data), 32'h41);
      chk("tx.hold", {30'd0, stall, resp_valid}, 2);
      if (i < 4) @(negedge CLK);
    end
    uart_tx_ready = 1;
    @(negedge CLK);
    chk("tx.resp", {30'd0, resp_valid, resp_err}, 2);
    chk("tx.after", 32'(uart_tx_valid), 0);
    // busy request ignored, accepted after RESP
    send(1, 2'b10, 0, 32'h10, 32'h5);
    req_valid = 1;
    @(negedge CLK);
    chk("b2b.resp", 32'(resp_valid), 1);
    chk("b2b.noen", 32'(mem_en), 0);
    @(negedge CLK);
    chk("b2b.ready", 32'(req_ready), 1);
    @(posedge CLK);
    #1 req_valid = 0;
    @(negedge CLK);
    chk("b2b.en2", 32'(mem_en), 1);
    wait_resp(lat);
    chk("b2b.lat2", 32'(lat), 2);
    // reset during WAIT
    send(0, 2'b10, 0, 32'h04, 0);
    @(negedge CLK);
    reset = 1;
    @(posedge CLK);
    #1 reset = 0;
    @(negedge CLK);
    chk("rstw.ready", 32'(req_ready), 1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) seen++;
      @(negedge CLK);
    end
    chk("rstw.noresp", 32'(seen), 0);
    // reset during TXHOLD
    uart_tx_ready = 0;
    send(1, 2'b00, 0, 32'h80000008, 32'h42);
    @(negedge CLK);
    reset = 1;
    @(posedge CLK);
    #1 reset = 0;
    @(negedge CLK);
    chk("rstt.txv", 32'(uart_tx_valid), 0);
    chk("rstt.ready", 32'(req_ready), 1);
    uart_tx_ready = 1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) seen++;
      @(negedge CLK);
    end
    chk("rstt.noresp", 32'(seen), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning data-memory word-address width.
REQ-002 SHALL have parameter MEM_LAT, default 1, legal range 1..7, meaning data-memory read latency in cycles after the mem_en cycle.
REQ-003 SHALL have parameter MMIO_TAG, default 4'h8, meaning the req_addr[31:28] value that selects the UART MMIO space.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports named CLK and reset.
REQ-005 Ports SHALL be as follows:
- CLK  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as error)
- req_signed  in  1  sign-extend sub-word loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  load result
- resp_err  out  1  misaligned or reserved access
- stall  out  1  unit busy
- mem_en  out  1  memory access strobe
- mem_we  out  4  byte-lane write enables; bit 3 = bits 31:24
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  memory read data
- uart_tx_data  out  8  transmit byte
- uart_tx_valid  out  1  transmit request
- uart_tx_ready  in  1  transmitter can accept a byte
- uart_rx_data  in  8  received byte
- uart_rx_valid  in  1  received byte available
- uart_rx_ready  out  1  one-cycle pulse that consumes the received byte

Function
REQ-006 States SHALL be IDLE, ISSUE, WAIT, TXHOLD and RESP; req_ready = 1 only in IDLE; stall = ~req_ready.
REQ-007 On accept (req_valid & req_ready, cycle T), the unit SHALL register we, size, signed, addr and wdata, then go to ISSUE.
REQ-008 Misalignment SHALL be: half access with addr[0]=1; word access with addr[1:0]≠0; req_size=11.
REQ-009 A misaligned access SHALL drive no memory or UART activity, go to RESP, and return resp_err=1 with resp_rdata=0.
REQ-010 Memory map:
- addr[31:28]≠MMIO_TAG → data memory, with mem_addr = addr[ADDR_W+1:2].
- addr[31:28]=MMIO_TAG → UART, decoded on addr[3:0]:
  - 0x0: read {31'b0, uart_tx_ready}
  - 0x4: read {31'b0, uart_rx_valid}
  - 0x8: write tx
  - 0xC: read rx
- Any other MMIO access SHALL complete with resp_err=0 and rdata=0, with no side effect.
REQ-011 ISSUE (cycle T+1), memory store: mem_en=1 for exactly one cycle, then go to RESP.
- Big-endian lanes: byte mem_we = 4'b1000 >> addr[1:0]; half mem_we = addr[1] ? 4'b0011 : 4'b1100; word mem_we = 4'b1111.
- mem_wdata = byte replicated 4×, half replicated 2×, or the full word.
REQ-012 ISSUE, memory load: mem_en=1 and mem_we=0 for one cycle, then go to WAIT.
- WAIT SHALL count MEM_LAT cycles.
- mem_rdata SHALL be sampled in cycle T+1+MEM_LAT, then go to RESP.
REQ-013 Load extraction (big-endian):
- byte offset 0 → bits 31:24 … offset 3 → bits 7:0.
- half offset 0 → bits 31:16; offset 2 → bits 15:0.
- Zero- or sign-extend to 32 bits per req_signed; word loads are unmodified.
REQ-014 MMIO tx write: go to TXHOLD, with uart_tx_data = wdata[7:0] and uart_tx_valid=1, held stable until a cycle with uart_tx_ready=1, then go to RESP.
REQ-015 MMIO rx read: in ISSUE, pulse uart_rx_ready for exactly one cycle and capture {24'b0, uart_rx_data}, even when uart_rx_valid=0.
REQ-016 RESP SHALL assert resp_valid for exactly one cycle and return to IDLE.
- Response timing: loads at T+2+MEM_LAT; stores, MMIO (except a stalled tx) and errors at T+2.
REQ-017 resp_rdata and resp_err SHALL be valid only while resp_valid=1; for stores resp_rdata=0.
REQ-018 A req_valid arriving while busy SHALL be ignored (not accepted) until req_ready=1; back-to-back requests SHALL be accepted in the cycle after RESP.
REQ-019 mem_en, mem_we, uart_tx_valid and uart_rx_ready SHALL be 0 in every state not named above.

Reset
REQ-020 While reset=1 at a CLK edge, the state SHALL become IDLE and the outputs SHALL be: req_ready=1, stall=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_en=0, mem_we=0, uart_tx_valid=0, uart_rx_ready=0.
REQ-021 Reset in any state, including mid-WAIT or TXHOLD, SHALL abort the request silently; no resp_valid SHALL follow for it.

Verification
REQ-022 With MEM_LAT=2, LB signed at addr 0x00000013 and mem_rdata=0x1122F344 → mem_en at T+1, resp_valid at T+4, resp_rdata=0x00000044; at addr 0x00000012 → resp_rdata=0xFFFFFFF3.
REQ-023 SH at addr 0x00000006 with wdata=0x0000BEEF → at T+1: mem_we=0011, mem_wdata=0xBEEFBEEF, mem_addr=1; resp_valid at T+2.
REQ-024 LW at addr 0x00000002 → no mem_en; resp_valid at T+2 with resp_err=1 and resp_rdata=0.
REQ-025 SB to 0x80000008 with wdata=0x41 and uart_tx_ready held low for 5 cycles → uart_tx_valid=1 with data 0x41 held throughout; resp_valid one cycle after ready rises; stall=1 throughout.
REQ-026 Load at 0x8000000C with uart_rx_data=0x5A → uart_rx_ready pulses once; resp_rdata=0x0000005A.
REQ-027 reset asserted in WAIT → next cycle req_ready=1, and no resp_valid appears for the aborted request.
